// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the toy-ALU program loader.
//   loader_state_t : run-controller state encoding
//   ALU_ADDR_W     : instruction-memory address width
//   ALU_DATA_W     : instruction byte width
//   ALU_MEM_DEPTH  : instruction-memory depth in bytes
package alu_pkg;

    localparam int unsigned ALU_ADDR_W    = 8;
    localparam int unsigned ALU_DATA_W    = 8;
    localparam int unsigned ALU_MEM_DEPTH = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_t;

endpackage

// File: rtl/alu_prog_loader_if.sv
// alu_prog_loader_if: command, byte-stream, fetch and status bundle of the loader.
//   master : controller / ALU side (drives commands, stream, fetch addresses)
//   slave  : loader side (drives in_ready, fetch data, step and status)
interface alu_prog_loader_if
    import alu_pkg::*;
#(
    parameter int unsigned ADDR_W = ALU_ADDR_W,
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned CNT_W  = 16
);
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              run_go;
    logic [CNT_W-1:0]  run_cycles;
    logic              abort;
    logic [ADDR_W-1:0] fetch_addr0;
    logic [ADDR_W-1:0] fetch_addr1;
    logic [DATA_W-1:0] fetch_data0;
    logic [DATA_W-1:0] fetch_data1;
    logic              step;
    logic              busy;
    logic              prog_valid;
    logic              done;
    logic              err;

    modport master (
        output load_start, load_len, in_valid, in_data, run_go, run_cycles, abort,
               fetch_addr0, fetch_addr1,
        input  in_ready, fetch_data0, fetch_data1, step, busy, prog_valid, done, err
    );

    modport slave (
        input  load_start, load_len, in_valid, in_data, run_go, run_cycles, abort,
               fetch_addr0, fetch_addr1,
        output in_ready, fetch_data0, fetch_data1, step, busy, prog_valid, done, err
    );

endinterface

// File: rtl/alu_imem.sv
// alu_imem: instruction memory, one synchronous write port, two asynchronous reads.
//   i_clk              : write clock
//   i_we/i_waddr/i_wdata : write port
//   i_raddr0/o_rdata0  : read port 0 (opcode fetch)
//   i_raddr1/o_rdata1  : read port 1 (immediate fetch)
// Contents are deliberately not reset.
module alu_imem
    import alu_pkg::*;
#(
    parameter int unsigned ADDR_W = ALU_ADDR_W,
    parameter int unsigned DATA_W = ALU_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr0,
    input  logic [ADDR_W-1:0] i_raddr1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/alu_prog_loader.sv
// alu_prog_loader: fills the instruction memory from a byte stream, serves the
// two ALU fetch reads and drives step for an exact number of cycles.
//   clk, rst : clock and synchronous active-high reset
//   bus      : load/run/abort commands, byte stream (valid/ready), fetch
//              addresses/data, step, busy, prog_valid, done, err
module alu_prog_loader
    import alu_pkg::*;
#(
    parameter int unsigned ADDR_W = ALU_ADDR_W,
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_prog_loader_if.slave  bus
);
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    loader_state_t    r_state, w_state_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;
    logic [LEN_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_step, r_done, r_err, r_prog_valid;
    logic             w_err_nxt, w_prog_valid_nxt;
    logic             w_we, w_len_ok;

    assign w_len_ok = (bus.load_len != '0) && (bus.load_len <= LEN_W'(DEPTH));

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_wr_ptr     <= '0;
            r_cnt        <= '0;
            r_step       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_prog_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_len        <= w_len_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_step       <= (w_state_nxt == ST_RUN);
            r_done       <= (w_state_nxt == ST_DONE);
            r_err        <= w_err_nxt;
            r_prog_valid <= w_prog_valid_nxt;
        end
    end

    // Next-state, counters and write strobe
    always_comb begin
        w_state_nxt      = r_state;
        w_len_nxt        = r_len;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_cnt_nxt        = r_cnt;
        w_err_nxt        = 1'b0;
        w_prog_valid_nxt = r_prog_valid;
        w_we             = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.load_start) begin
                    if (w_len_ok) begin
                        w_len_nxt    = bus.load_len;
                        w_wr_ptr_nxt = '0;
                        w_state_nxt  = ST_LOAD;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (bus.run_go) begin
                    w_err_nxt = 1'b1;
                end
            end

            ST_LOAD: begin
                if (bus.abort) begin
                    w_state_nxt      = ST_IDLE;
                    w_prog_valid_nxt = 1'b0;
                end else if (bus.in_valid) begin
                    w_we         = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + LEN_W'(1);
                    if (r_wr_ptr == r_len - LEN_W'(1)) begin
                        w_state_nxt      = ST_READY;
                        w_prog_valid_nxt = 1'b1;
                    end
                end
            end

            ST_READY: begin
                // load_start outranks a simultaneous run_go, which is dropped silently
                if (bus.load_start) begin
                    if (w_len_ok) begin
                        w_len_nxt        = bus.load_len;
                        w_wr_ptr_nxt     = '0;
                        w_state_nxt      = ST_LOAD;
                        w_prog_valid_nxt = 1'b0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (bus.run_go) begin
                    w_cnt_nxt   = bus.run_cycles;
                    w_state_nxt = (bus.run_cycles == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.load_start || bus.run_go) begin
                    w_err_nxt = 1'b1;
                end
                if (bus.abort) begin
                    w_state_nxt = ST_READY;
                end else begin
                    // counter holds the steps still owed including this cycle
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_READY;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    alu_imem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_imem (
        .i_clk    (clk),
        .i_we     (w_we && !rst),
        .i_waddr  (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata  (bus.in_data),
        .i_raddr0 (bus.fetch_addr0),
        .i_raddr1 (bus.fetch_addr1),
        .o_rdata0 (bus.fetch_data0),
        .o_rdata1 (bus.fetch_data1)
    );

    assign bus.in_ready   = (r_state == ST_LOAD);
    assign bus.busy       = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign bus.step       = r_step;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.prog_valid = r_prog_valid;

endmodule
